// File: rtl/wt_dcache_ship_trainer_if.sv
// Bundle of event, predictor-update, lookup and insertion signals between the
// wt_dcache controller side and the SHiP training logic.
// The slave modport is the trainer's view; master is the controller/predictor view.
interface wt_dcache_ship_trainer_if #(
    parameter int NumSets  = 256,
    parameter int NumWays  = 4,
    parameter int SigWidth = 14
);
    logic                        flush_i;
    logic                        evt_valid_i;
    logic                        evt_ready_o;
    logic                        evt_fill_i;
    logic [$clog2(NumSets)-1:0]  evt_set_i;
    logic [$clog2(NumWays)-1:0]  evt_way_i;
    logic [SigWidth-1:0]         evt_sig_i;
    logic                        upd_valid_o;
    logic                        upd_ready_i;
    logic                        upd_inc_o;
    logic [SigWidth-1:0]         upd_sig_o;
    logic [SigWidth-1:0]         pred_sig_o;
    logic [1:0]                  pred_result_i;
    logic                        ins_valid_o;
    logic [1:0]                  ins_rrpv_o;

    modport slave (
        input  flush_i, evt_valid_i, evt_fill_i, evt_set_i, evt_way_i, evt_sig_i,
               upd_ready_i, pred_result_i,
        output evt_ready_o, upd_valid_o, upd_inc_o, upd_sig_o, pred_sig_o,
               ins_valid_o, ins_rrpv_o
    );

    modport master (
        output flush_i, evt_valid_i, evt_fill_i, evt_set_i, evt_way_i, evt_sig_i,
               upd_ready_i, pred_result_i,
        input  evt_ready_o, upd_valid_o, upd_inc_o, upd_sig_o, pred_sig_o,
               ins_valid_o, ins_rrpv_o
    );
endinterface

// File: rtl/wt_dcache_ship_trainer.sv
// wt_dcache_ship_trainer: training-side companion of the dcache SHiP predictor.
// Keeps per-line signature/outcome/valid metadata, turns hit and fill events into
// increment/decrement requests buffered in a small FIFO, and returns an insertion
// RRPV for every fill from the predictor's answer on the incoming signature.
// Optional feature: define WT_DCACHE_SHIP_STATS_EN to add saturating statistics
// counters for popped increments, popped decrements and stalled event cycles.
module wt_dcache_ship_trainer #(
    parameter int NumSets   = 256,
    parameter int NumWays   = 4,
    parameter int SigWidth  = 14,
    parameter int FifoDepth = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    wt_dcache_ship_trainer_if.slave bus
`ifdef WT_DCACHE_SHIP_STATS_EN
    ,
    output logic [31:0]             stat_inc_o,
    output logic [31:0]             stat_dec_o,
    output logic [31:0]             stat_stall_o
`endif
);
    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(FifoDepth);

    typedef struct packed {
        logic                inc;
        logic [SigWidth-1:0] sig;
    } updEntry_t;

    logic                lineValid_q   [NumSets][NumWays];
    logic                lineOutcome_q [NumSets][NumWays];
    logic [SigWidth-1:0] lineSig_q     [NumSets][NumWays];

    updEntry_t           fifoMem_q [FifoDepth];
    logic [PtrW-1:0]     wrPtr_q, rdPtr_q;
    logic [CntW-1:0]     count_q, count_d;

    logic                insValid_q;
    logic [1:0]          insRrpv_q;

    logic                fifoFull, fifoEmpty, evtReady, evtAccept;
    logic                victimValid, victimOutcome;
    logic [SigWidth-1:0] victimSig;
    logic                pushEn, popEn;
    updEntry_t           pushEntry, headEntry;

    assign fifoFull      = (count_q == FullCount);
    assign fifoEmpty     = (count_q == '0);
    assign evtReady      = !fifoFull && !bus.flush_i;
    assign evtAccept     = bus.evt_valid_i && evtReady;
    assign victimValid   = lineValid_q[bus.evt_set_i][bus.evt_way_i];
    assign victimOutcome = lineOutcome_q[bus.evt_set_i][bus.evt_way_i];
    assign victimSig     = lineSig_q[bus.evt_set_i][bus.evt_way_i];
    assign popEn         = !fifoEmpty && bus.upd_ready_i;
    assign headEntry     = fifoMem_q[rdPtr_q];

    assign bus.evt_ready_o = evtReady;
    assign bus.upd_valid_o = !fifoEmpty;
    assign bus.upd_inc_o   = headEntry.inc;
    assign bus.upd_sig_o   = headEntry.sig;
    assign bus.pred_sig_o  = bus.evt_sig_i;
    assign bus.ins_valid_o = insValid_q;
    assign bus.ins_rrpv_o  = insRrpv_q;

    // Decide whether the accepted event produces an update: hits on valid lines
    // reward their signature, evicting a never-reused valid line punishes it.
    always_comb begin
        pushEn    = 1'b0;
        pushEntry = '0;
        if (evtAccept && victimValid) begin
            if (!bus.evt_fill_i) begin
                pushEn    = 1'b1;
                pushEntry = '{inc: 1'b1, sig: victimSig};
            end else if (!victimOutcome) begin
                pushEn    = 1'b1;
                pushEntry = '{inc: 1'b0, sig: victimSig};
            end
        end
    end

    // FIFO occupancy: simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        case ({pushEn, popEn})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Per-line metadata; flush drops validity and outcome but keeps signatures.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NumSets; s++) begin
                for (int w = 0; w < NumWays; w++) begin
                    lineValid_q[s][w]   <= 1'b0;
                    lineOutcome_q[s][w] <= 1'b0;
                    lineSig_q[s][w]     <= '0;
                end
            end
        end else if (bus.flush_i) begin
            for (int s = 0; s < NumSets; s++) begin
                for (int w = 0; w < NumWays; w++) begin
                    lineValid_q[s][w]   <= 1'b0;
                    lineOutcome_q[s][w] <= 1'b0;
                end
            end
        end else if (evtAccept) begin
            if (bus.evt_fill_i) begin
                lineSig_q[bus.evt_set_i][bus.evt_way_i]     <= bus.evt_sig_i;
                lineOutcome_q[bus.evt_set_i][bus.evt_way_i] <= 1'b0;
                lineValid_q[bus.evt_set_i][bus.evt_way_i]   <= 1'b1;
            end else if (victimValid) begin
                lineOutcome_q[bus.evt_set_i][bus.evt_way_i] <= 1'b1;
            end
        end
    end

    // Circular update FIFO; new entries only become visible on the next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < FifoDepth; i++) begin
                fifoMem_q[i] <= '0;
            end
        end else if (bus.flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushEn) begin
                fifoMem_q[wrPtr_q] <= pushEntry;
                wrPtr_q            <= wrPtr_q + 1'b1;
            end
            if (popEn) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Insertion RRPV: distant (3) for signatures predicted dead, else long (2).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            insValid_q <= 1'b0;
            insRrpv_q  <= 2'd0;
        end else if (bus.flush_i) begin
            insValid_q <= 1'b0;
        end else begin
            insValid_q <= evtAccept && bus.evt_fill_i;
            if (evtAccept && bus.evt_fill_i) begin
                insRrpv_q <= (bus.pred_result_i == 2'd0) ? 2'd3 : 2'd2;
            end
        end
    end

`ifdef WT_DCACHE_SHIP_STATS_EN
    logic [31:0] statInc_q, statDec_q, statStall_q;

    assign stat_inc_o   = statInc_q;
    assign stat_dec_o   = statDec_q;
    assign stat_stall_o = statStall_q;

    // Saturating counters of popped updates and back-pressured event cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            statInc_q   <= '0;
            statDec_q   <= '0;
            statStall_q <= '0;
        end else if (bus.flush_i) begin
            statInc_q   <= '0;
            statDec_q   <= '0;
            statStall_q <= '0;
        end else begin
            if (popEn && headEntry.inc && (statInc_q != '1)) begin
                statInc_q <= statInc_q + 32'd1;
            end
            if (popEn && !headEntry.inc && (statDec_q != '1)) begin
                statDec_q <= statDec_q + 32'd1;
            end
            if (bus.evt_valid_i && !evtReady && (statStall_q != '1)) begin
                statStall_q <= statStall_q + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_wt_dcache_ship_trainer.sv
// Self-checking bench for wt_dcache_ship_trainer: directed scenarios followed by
// randomized events, all compared against a queue/array reference model.
module tb_wt_dcache_ship_trainer;
    localparam int NumSets   = 256;
    localparam int NumWays   = 4;
    localparam int SigWidth  = 14;
    localparam int FifoDepth = 4;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    always #5 clk_i = ~clk_i;

    wt_dcache_ship_trainer_if #(.NumSets(NumSets), .NumWays(NumWays), .SigWidth(SigWidth)) bus();

`ifdef WT_DCACHE_SHIP_STATS_EN
    logic [31:0] statInc, statDec, statStall;
`endif

    wt_dcache_ship_trainer #(
        .NumSets(NumSets), .NumWays(NumWays), .SigWidth(SigWidth), .FifoDepth(FifoDepth)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
`ifdef WT_DCACHE_SHIP_STATS_EN
        ,
        .stat_inc_o   (statInc),
        .stat_dec_o   (statDec),
        .stat_stall_o (statStall)
`endif
    );

    typedef struct packed {
        logic                inc;
        logic [SigWidth-1:0] sig;
    } updEntry_t;

    int vectorCount = 0;
    int missCount   = 0;

    bit                  refValid   [NumSets][NumWays];
    bit                  refOutcome [NumSets][NumWays];
    logic [SigWidth-1:0] refSig     [NumSets][NumWays];
    updEntry_t           refQueue[$];
    bit                  refInsValid;
    logic [1:0]          refInsRrpv;
    int unsigned         refStatInc, refStatDec, refStatStall;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        for (int s = 0; s < NumSets; s++) begin
            for (int w = 0; w < NumWays; w++) begin
                refValid[s][w]   = 1'b0;
                refOutcome[s][w] = 1'b0;
                refSig[s][w]     = '0;
            end
        end
        refQueue.delete();
        refInsValid  = 1'b0;
        refInsRrpv   = 2'd0;
        refStatInc   = 0;
        refStatDec   = 0;
        refStatStall = 0;
    endtask

    task automatic checkState();
        checkOutput("upd_valid", 32'(bus.upd_valid_o), 32'(refQueue.size() != 0));
        if (refQueue.size() != 0) begin
            checkOutput("upd_inc", 32'(bus.upd_inc_o), 32'(refQueue[0].inc));
            checkOutput("upd_sig", 32'(bus.upd_sig_o), 32'(refQueue[0].sig));
        end
        checkOutput("ins_valid", 32'(bus.ins_valid_o), 32'(refInsValid));
        checkOutput("ins_rrpv", 32'(bus.ins_rrpv_o), 32'(refInsRrpv));
`ifdef WT_DCACHE_SHIP_STATS_EN
        checkOutput("stat_inc", statInc, refStatInc);
        checkOutput("stat_dec", statDec, refStatDec);
        checkOutput("stat_stall", statStall, refStatStall);
`endif
    endtask

    // One clock of stimulus, entered and left at a falling edge.
    task automatic applyStimulus(input logic valid, input logic fill, input logic [7:0] set,
                                 input logic [1:0] way, input logic [SigWidth-1:0] sig,
                                 input logic updReady, input logic flush, input logic [1:0] pred);
        bit expReady, accept, popped, poppedInc;
        bus.evt_valid_i   = valid;
        bus.evt_fill_i    = fill;
        bus.evt_set_i     = set;
        bus.evt_way_i     = way;
        bus.evt_sig_i     = sig;
        bus.upd_ready_i   = updReady;
        bus.flush_i       = flush;
        bus.pred_result_i = pred;
        #1;
        expReady = (refQueue.size() < FifoDepth) && !flush;
        checkOutput("evt_ready", 32'(bus.evt_ready_o), 32'(expReady));
        checkOutput("pred_sig", 32'(bus.pred_sig_o), 32'(sig));
        @(posedge clk_i);
        accept    = valid && expReady;
        popped    = (refQueue.size() != 0) && updReady;
        poppedInc = 1'b0;
        if (popped) begin
            poppedInc = refQueue[0].inc;
            void'(refQueue.pop_front());
        end
        if (flush) begin
            for (int s = 0; s < NumSets; s++) begin
                for (int w = 0; w < NumWays; w++) begin
                    refValid[s][w]   = 1'b0;
                    refOutcome[s][w] = 1'b0;
                end
            end
            refQueue.delete();
            refInsValid  = 1'b0;
            refStatInc   = 0;
            refStatDec   = 0;
            refStatStall = 0;
        end else begin
            if (popped && poppedInc) refStatInc++;
            if (popped && !poppedInc) refStatDec++;
            if (valid && !expReady) refStatStall++;
            refInsValid = accept && fill;
            if (accept && fill) begin
                if (refValid[set][way] && !refOutcome[set][way])
                    refQueue.push_back('{inc: 1'b0, sig: refSig[set][way]});
                refSig[set][way]     = sig;
                refOutcome[set][way] = 1'b0;
                refValid[set][way]   = 1'b1;
                refInsRrpv           = (pred == 2'd0) ? 2'd3 : 2'd2;
            end else if (accept && refValid[set][way]) begin
                refOutcome[set][way] = 1'b1;
                refQueue.push_back('{inc: 1'b1, sig: refSig[set][way]});
            end
        end
        @(negedge clk_i);
        checkState();
    endtask

    task automatic idle(input logic updReady);
        applyStimulus(1'b0, 1'b0, 8'd0, 2'd0, '0, updReady, 1'b0, 2'd0);
    endtask

    initial begin
        logic [7:0] setPool [4];
        int         readyPct;
        setPool[0] = 8'd0;
        setPool[1] = 8'd5;
        setPool[2] = 8'd7;
        setPool[3] = 8'd255;

        bus.flush_i = 1'b0; bus.evt_valid_i = 1'b0; bus.evt_fill_i = 1'b0;
        bus.evt_set_i = '0; bus.evt_way_i = '0; bus.evt_sig_i = '0;
        bus.upd_ready_i = 1'b0; bus.pred_result_i = 2'd0;
        resetModel();
        repeat (2) @(negedge clk_i);
        checkOutput("reset upd_valid", 32'(bus.upd_valid_o), 32'd0);
        rst_ni = 1'b1;
        #1;
        checkOutput("reset evt_ready", 32'(bus.evt_ready_o), 32'd1);
        checkOutput("reset upd_inc", 32'(bus.upd_inc_o), 32'd0);
        checkOutput("reset upd_sig", 32'(bus.upd_sig_o), 32'd0);
        checkOutput("reset ins_valid", 32'(bus.ins_valid_o), 32'd0);
        checkOutput("reset ins_rrpv", 32'(bus.ins_rrpv_o), 32'd0);
        @(negedge clk_i);

        $display("[TB] directed: fill, hit, eviction");
        applyStimulus(1'b1, 1'b1, 8'd5, 2'd2, 14'h1A3, 1'b1, 1'b0, 2'd0);
        checkOutput("fill rrpv distant", 32'(bus.ins_rrpv_o), 32'd3);
        applyStimulus(1'b1, 1'b0, 8'd5, 2'd2, 14'h0, 1'b1, 1'b0, 2'd1);
        checkOutput("hit inc sig", 32'(bus.upd_sig_o), 32'h1A3);
        idle(1'b1);
        applyStimulus(1'b1, 1'b1, 8'd7, 2'd0, 14'h055, 1'b1, 1'b0, 2'd2);
        checkOutput("fill rrpv long", 32'(bus.ins_rrpv_o), 32'd2);
        applyStimulus(1'b1, 1'b1, 8'd7, 2'd0, 14'h3FF, 1'b1, 1'b0, 2'd0);
        checkOutput("evict dec sig", 32'(bus.upd_sig_o), 32'h055);
        idle(1'b1);

        $display("[TB] directed: full FIFO back-pressure");
        applyStimulus(1'b1, 1'b0, 8'd5, 2'd2, '0, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0, 8'd7, 2'd0, '0, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0, 8'd5, 2'd2, '0, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0, 8'd7, 2'd0, '0, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0, 8'd5, 2'd2, '0, 1'b0, 1'b0, 2'd0);
        checkOutput("full head sig", 32'(bus.upd_sig_o), 32'h1A3);
        repeat (5) idle(1'b1);

        $display("[TB] directed: flush");
        applyStimulus(1'b1, 1'b0, 8'd5, 2'd2, '0, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0, 8'd7, 2'd0, '0, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0, 8'd5, 2'd2, '0, 1'b0, 1'b1, 2'd0);
        applyStimulus(1'b1, 1'b0, 8'd5, 2'd2, '0, 1'b1, 1'b0, 2'd0);
        idle(1'b1);

        $display("[TB] directed: reset with queued updates");
        applyStimulus(1'b1, 1'b1, 8'd5, 2'd2, 14'h077, 1'b0, 1'b0, 2'd1);
        repeat (3) applyStimulus(1'b1, 1'b0, 8'd5, 2'd2, '0, 1'b0, 1'b0, 2'd0);
        rst_ni = 1'b0;
        #1;
        checkOutput("async reset upd_valid", 32'(bus.upd_valid_o), 32'd0);
        resetModel();
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        checkOutput("post reset evt_ready", 32'(bus.evt_ready_o), 32'd1);
        checkOutput("post reset ins_rrpv", 32'(bus.ins_rrpv_o), 32'd0);
        @(negedge clk_i);
        checkState();

        $display("[TB] random phase");
        readyPct = 50;
        for (int n = 0; n < 800; n++) begin
            if (n % 40 == 0) readyPct = $urandom_range(10, 90);
            applyStimulus(($urandom_range(0, 99) < 70),
                          ($urandom_range(0, 99) < 40),
                          setPool[$urandom_range(0, 3)],
                          2'($urandom_range(0, 3)),
                          SigWidth'($urandom),
                          ($urandom_range(0, 99) < readyPct),
                          ($urandom_range(0, 99) < 2),
                          2'($urandom_range(0, 3)));
        end
        repeat (FifoDepth + 1) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
